alu_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the shared 4-bit `ALU` datapath (operands `a`, `b`, select `s`, 8-bit result `y`). It accepts operation requests over valid/ready handshakes and grants them round-robin. It drives the ALU from registered operands, captures the result, and returns it on a single tagged response channel. It sits between the ALU and its two client blocks, so the ALU is never driven by more than one source.

---
 rtl/alu_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_alu_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Two-requester round-robin arbiter and sequencer for a shared combinational
// ALU. One operation is in flight at a time:
//   IDLE : grant one valid requester (combinational ready) and latch its
//          operands and index on the clock edge.
//   EXEC : registered operands drive the ALU for one full cycle. The result
//          is captured at the end of that cycle.
//   RESP : the result is presented, tagged with the owner, until it is
//          accepted.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   req{0,1}_valid / _ready      request handshake (ready is high only in IDLE)
//   req{0,1}_a, _b, _s           operands and operation select
//   alu_a, alu_b, alu_s          registered operands to the ALU
//   alu_y                        combinational ALU result (full YW width)
//   rsp_valid / rsp_ready        response handshake
//   rsp_id, rsp_y                owner tag and captured result
//   busy                         high whenever an operation is in flight
//   op_count                     completed responses, wraps modulo 2**CW
// -----------------------------------------------------------------------------
module alu_arbiter #(
  parameter int DW = 4,
  parameter int SW = 4,
  parameter int YW = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [DW-1:0] req0_a,
  input  logic [DW-1:0] req0_b,
  input  logic [SW-1:0] req0_s,

  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [DW-1:0] req1_a,
  input  logic [DW-1:0] req1_b,
  input  logic [SW-1:0] req1_s,

  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [SW-1:0] alu_s,
  input  logic [YW-1:0] alu_y,

  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_id,
  output logic [YW-1:0] rsp_y,

  output logic          busy,
  output logic [CW-1:0] op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] alu_a_q, alu_a_d;
  logic [DW-1:0] alu_b_q, alu_b_d;
  logic [SW-1:0] alu_s_q, alu_s_d;
  logic          tag_q, tag_d;        // index of the in-flight requester
  logic          rsp_id_q, rsp_id_d;
  logic [YW-1:0] rsp_y_q, rsp_y_d;
  logic [CW-1:0] op_count_q, op_count_d;
  logic          last_q, last_d;      // requester granted most recently

  logic grant0;
  logic grant1;
  logic accept;

  // ---------------------------------------------------------------------------
  // Arbitration. Grants exist only in IDLE and never while reset is asserted,
  // so at most one ready is high in any cycle. On a tie the requester that was
  // not granted last wins; last_q resets to 1 so requester 0 wins the first tie.
  // ---------------------------------------------------------------------------
  // NOTE: every signal written in an always_comb gets a value on every path
  // (here and below, defaults first); otherwise a latch is inferred.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == IDLE && !rst) begin
      if (req0_valid && req1_valid) begin
        grant0 = last_q;
        grant1 = !last_q;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign accept = grant0 | grant1;

  // ---------------------------------------------------------------------------
  // Next-state and datapath. Every register holds by default; operands and the
  // last-grant pointer move only on acceptance, the result only at end of EXEC.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_s_d    = alu_s_q;
    tag_d      = tag_q;
    rsp_id_d   = rsp_id_q;
    rsp_y_d    = rsp_y_q;
    op_count_d = op_count_q;
    last_d     = last_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = EXEC;
          alu_a_d = grant1 ? req1_a : req0_a;
          alu_b_d = grant1 ? req1_b : req0_b;
          alu_s_d = grant1 ? req1_s : req0_s;
          tag_d   = grant1;
          last_d  = grant1;
        end
      end
      EXEC: begin
        // The ALU has seen stable operands for the whole cycle; take its
        // result at full width.
        rsp_y_d  = alu_y;
        rsp_id_d = tag_q;
        state_d  = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          op_count_d = op_count_q + CW'(1);
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers. Reset drops any in-flight operation without a response
  // or a count update.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_s_q    <= '0;
      tag_q      <= 1'b0;
      rsp_id_q   <= 1'b0;
      rsp_y_q    <= '0;
      op_count_q <= '0;
      last_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_s_q    <= alu_s_d;
      tag_q      <= tag_d;
      rsp_id_q   <= rsp_id_d;
      rsp_y_q    <= rsp_y_d;
      op_count_q <= op_count_d;
      last_q     <= last_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_s      = alu_s_q;
  assign rsp_valid  = (state_q == RESP);
  assign rsp_id     = rsp_id_q;
  assign rsp_y      = rsp_y_q;
  assign busy       = (state_q != IDLE);
  assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//
// Self-checking bench for alu_arbiter. A reference ALU function drives alu_y
// from the DUT's registered operands. A second instance with CW=2 sees the
// same stimulus so the counter wrap can be observed. Each cycle, every
// output is compared against a transaction-level model: one optional
// in-flight operation with the cycle it was accepted in, a last-grant index
// and a completion count. A directed table and a few hand-written sequences
// run first, then randomized traffic.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

  logic       clk;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic [3:0] req0_a, req0_b, req0_s;
  logic [3:0] req1_a, req1_b, req1_s;
  logic       rsp_ready;

  logic       req0_ready, req1_ready;
  logic [3:0] alu_a, alu_b, alu_s;
  logic [7:0] alu_y;
  logic       rsp_valid, rsp_id;
  logic [7:0] rsp_y;
  logic       busy;
  logic [7:0] op_count;

  logic       w_req0_ready, w_req1_ready;
  logic [3:0] w_alu_a, w_alu_b, w_alu_s;
  logic [7:0] w_alu_y;
  logic       w_rsp_valid, w_rsp_id;
  logic [7:0] w_rsp_y;
  logic       w_busy;
  logic [1:0] w_op_count;

  int n_vec;
  int n_err;

  // Reference ALU: arbitrary but fully specified 8-bit function of a, b, s.
  function automatic logic [7:0] ref_alu(input logic [3:0] a, input logic [3:0] b,
                                         input logic [3:0] s);
    logic [7:0] xa;
    logic [7:0] xb;
    xa = {4'h0, a};
    xb = {4'h0, b};
    case (s)
      4'd0:    return xa + xb;
      4'd1:    return xa - xb;
      4'd2:    return xa * xb;
      4'd3:    return xa & xb;
      4'd4:    return xa | xb;
      4'd5:    return xa ^ xb;
      4'd6:    return {4'h0, ~a};
      4'd7:    return {4'h0, ~b};
      4'd8:    return {a, b};
      4'd9:    return {b, a};
      4'd10:   return xa >> 1;
      4'd11:   return xa << 1;
      4'd12:   return {7'h0, a == b};
      4'd13:   return {7'h0, a < b};
      4'd14:   return 8'hFF;
      default: return xa + xb + 8'd1;
    endcase
  endfunction

  assign alu_y   = ref_alu(alu_a, alu_b, alu_s);
  assign w_alu_y = ref_alu(w_alu_a, w_alu_b, w_alu_s);

  alu_arbiter #(.DW(4), .SW(4), .YW(8), .CW(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_s(req0_s),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_s(req1_s),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_y(alu_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_y(rsp_y),
    .busy(busy), .op_count(op_count)
  );

  alu_arbiter #(.DW(4), .SW(4), .YW(8), .CW(2)) dut_wrap (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(w_req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_s(req0_s),
    .req1_valid(req1_valid), .req1_ready(w_req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_s(req1_s),
    .alu_a(w_alu_a), .alu_b(w_alu_b), .alu_s(w_alu_s), .alu_y(w_alu_y),
    .rsp_valid(w_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(w_rsp_id), .rsp_y(w_rsp_y),
    .busy(w_busy), .op_count(w_op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Transaction-level model
  // ---------------------------------------------------------------------------
  int         m_cyc  = 0;
  bit         m_have = 1'b0;  // an operation is in flight
  int         m_acc  = 0;     // cycle in which it was accepted
  int         m_last = 1;     // requester granted most recently
  int         m_cnt  = 0;     // completed responses
  int         m_id   = 0;
  logic [7:0] m_y    = 8'h00;
  logic [3:0] m_a    = 4'h0;
  logic [3:0] m_b    = 4'h0;
  logic [3:0] m_s    = 4'h0;

  task automatic drive(input logic r, input logic v0, input logic [3:0] a0,
                       input logic [3:0] b0, input logic [3:0] s0, input logic v1,
                       input logic [3:0] a1, input logic [3:0] b1, input logic [3:0] s1,
                       input logic rr);
    rst = r;
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_s = s0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_s = s1;
    rsp_ready = rr;
  endtask

  // Compare all outputs mid-cycle against the model, then advance the model
  // across the coming edge using this cycle's inputs.
  task automatic sample();
    int win;
    bit e_rv;
    @(negedge clk);
    win = -1;
    if (!m_have && !rst) begin
      if (req0_valid && req1_valid) win = (m_last == 1) ? 0 : 1;
      else if (req0_valid)          win = 0;
      else if (req1_valid)          win = 1;
    end
    e_rv = m_have && (m_cyc >= m_acc + 2);

    check("req0_ready", req0_ready, win == 0);
    check("req1_ready", req1_ready, win == 1);
    check("busy", busy, m_have);
    check("rsp_valid", rsp_valid, e_rv);
    check("alu_a", alu_a, m_a);
    check("alu_b", alu_b, m_b);
    check("alu_s", alu_s, m_s);
    check("op_count", op_count, m_cnt % 256);
    check("wrap_op_count", w_op_count, m_cnt % 4);
    check("wrap_busy", w_busy, m_have);
    if (e_rv) begin
      check("rsp_id", rsp_id, m_id);
      check("rsp_y", rsp_y, m_y);
    end

    if (rst) begin
      m_have = 1'b0; m_last = 1; m_cnt = 0;
      m_a = 4'h0; m_b = 4'h0; m_s = 4'h0;
    end else if (win == 0) begin
      m_have = 1'b1; m_acc = m_cyc; m_id = 0; m_last = 0;
      m_a = req0_a; m_b = req0_b; m_s = req0_s;
      m_y = ref_alu(req0_a, req0_b, req0_s);
    end else if (win == 1) begin
      m_have = 1'b1; m_acc = m_cyc; m_id = 1; m_last = 1;
      m_a = req1_a; m_b = req1_b; m_s = req1_s;
      m_y = ref_alu(req1_a, req1_b, req1_s);
    end else if (e_rv && rsp_ready) begin
      m_have = 1'b0;
      m_cnt++;
    end
    m_cyc++;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  // ---------------------------------------------------------------------------
  // Directed table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic       rst;
    logic       v0;
    logic [3:0] a0, b0, s0;
    logic       v1;
    logic [3:0] a1, b1, s1;
    logic       rr;
    logic       e_r0, e_r1, e_busy, e_rv, e_id;
    logic [7:0] e_y;
    logic [3:0] e_alu_a;
    logic [7:0] e_cnt;
  } vec_t;

  localparam int NTBL = 19;
  vec_t tbl [NTBL];

  function automatic vec_t mk(input logic r, input logic v0, input logic [3:0] a0,
                              input logic [3:0] b0, input logic [3:0] s0, input logic v1,
                              input logic [3:0] a1, input logic [3:0] b1,
                              input logic [3:0] s1, input logic e_r0, input logic e_r1,
                              input logic e_busy, input logic e_rv, input logic e_id,
                              input logic [7:0] e_y, input logic [3:0] e_alu_a,
                              input logic [7:0] e_cnt);
    vec_t v;
    v.rst = r; v.v0 = v0; v.a0 = a0; v.b0 = b0; v.s0 = s0;
    v.v1 = v1; v.a1 = a1; v.b1 = b1; v.s1 = s1; v.rr = 1'b1;
    v.e_r0 = e_r0; v.e_r1 = e_r1; v.e_busy = e_busy; v.e_rv = e_rv; v.e_id = e_id;
    v.e_y = e_y; v.e_alu_a = e_alu_a; v.e_cnt = e_cnt;
    return v;
  endfunction

  initial begin
    logic [7:0] y_single, y_t0, y_t1, held_y;
    logic       held_id;

    n_vec = 0;
    n_err = 0;
    y_single = ref_alu(4'hA, 4'h9, 4'h0);
    y_t0     = ref_alu(4'h3, 4'h4, 4'h1);
    y_t1     = ref_alu(4'h5, 4'h6, 4'h2);

    //              rst v0 a0    b0    s0    v1 a1    b1    s1     r0 r1 bs rv id y         alu_a cnt
    // Reset, then a single request from requester 0.
    tbl[0]  = mk(1, 1, 4'hA, 4'h9, 4'h0, 1, 4'h5, 4'h6, 4'h2, 0, 0, 0, 0, 0, 8'h00,    4'h0, 8'd0);
    tbl[1]  = mk(0, 1, 4'hA, 4'h9, 4'h0, 0, 4'h0, 4'h0, 4'h0, 1, 0, 0, 0, 0, 8'h00,    4'h0, 8'd0);
    tbl[2]  = mk(0, 0, 4'h0, 4'h0, 4'h0, 0, 4'h0, 4'h0, 4'h0, 0, 0, 1, 0, 0, 8'h00,    4'hA, 8'd0);
    tbl[3]  = mk(0, 0, 4'h0, 4'h0, 4'h0, 0, 4'h0, 4'h0, 4'h0, 0, 0, 1, 1, 0, y_single, 4'hA, 8'd0);
    tbl[4]  = mk(0, 0, 4'h0, 4'h0, 4'h0, 0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 8'h00,    4'hA, 8'd1);
    // Reset again, then both requesters continuously valid: 0,1,0,1 every 3 cycles.
    tbl[5]  = mk(1, 1, 4'h3, 4'h4, 4'h1, 1, 4'h5, 4'h6, 4'h2, 0, 0, 0, 0, 0, 8'h00,    4'hA, 8'd1);
    tbl[6]  = mk(0, 1, 4'h3, 4'h4, 4'h1, 1, 4'h5, 4'h6, 4'h2, 1, 0, 0, 0, 0, 8'h00,    4'h0, 8'd0);
    tbl[7]  = mk(0, 1, 4'h3, 4'h4, 4'h1, 1, 4'h5, 4'h6, 4'h2, 0, 0, 1, 0, 0, 8'h00,    4'h3, 8'd0);
    tbl[8]  = mk(0, 1, 4'h3, 4'h4, 4'h1, 1, 4'h5, 4'h6, 4'h2, 0, 0, 1, 1, 0, y_t0,     4'h3, 8'd0);
    tbl[9]  = mk(0, 1, 4'h3, 4'h4, 4'h1, 1, 4'h5, 4'h6, 4'h2, 0, 1, 0, 0, 0, 8'h00,    4'h3, 8'd1);
    tbl[10] = mk(0, 1, 4'h3, 4'h4, 4'h1, 1, 4'h5, 4'h6, 4'h2, 0, 0, 1, 0, 0, 8'h00,    4'h5, 8'd1);
    tbl[11] = mk(0, 1, 4'h3, 4'h4, 4'h1, 1, 4'h5, 4'h6, 4'h2, 0, 0, 1, 1, 1, y_t1,     4'h5, 8'd1);
    tbl[12] = mk(0, 1, 4'h3, 4'h4, 4'h1, 1, 4'h5, 4'h6, 4'h2, 1, 0, 0, 0, 0, 8'h00,    4'h5, 8'd2);
    tbl[13] = mk(0, 1, 4'h3, 4'h4, 4'h1, 1, 4'h5, 4'h6, 4'h2, 0, 0, 1, 0, 0, 8'h00,    4'h3, 8'd2);
    tbl[14] = mk(0, 1, 4'h3, 4'h4, 4'h1, 1, 4'h5, 4'h6, 4'h2, 0, 0, 1, 1, 0, y_t0,     4'h3, 8'd2);
    tbl[15] = mk(0, 1, 4'h3, 4'h4, 4'h1, 1, 4'h5, 4'h6, 4'h2, 0, 1, 0, 0, 0, 8'h00,    4'h3, 8'd3);
    tbl[16] = mk(0, 0, 4'h0, 4'h0, 4'h0, 0, 4'h0, 4'h0, 4'h0, 0, 0, 1, 0, 0, 8'h00,    4'h5, 8'd3);
    tbl[17] = mk(0, 0, 4'h0, 4'h0, 4'h0, 0, 4'h0, 4'h0, 4'h0, 0, 0, 1, 1, 1, y_t1,     4'h5, 8'd3);
    tbl[18] = mk(0, 0, 4'h0, 4'h0, 4'h0, 0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 8'h00,    4'h5, 8'd4);

    for (int i = 0; i < NTBL; i++) begin
      drive(tbl[i].rst, tbl[i].v0, tbl[i].a0, tbl[i].b0, tbl[i].s0,
            tbl[i].v1, tbl[i].a1, tbl[i].b1, tbl[i].s1, tbl[i].rr);
      sample();
      check($sformatf("tbl%0d_req0_ready", i), req0_ready, tbl[i].e_r0);
      check($sformatf("tbl%0d_req1_ready", i), req1_ready, tbl[i].e_r1);
      check($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
      check($sformatf("tbl%0d_rsp_valid", i), rsp_valid, tbl[i].e_rv);
      check($sformatf("tbl%0d_alu_a", i), alu_a, tbl[i].e_alu_a);
      check($sformatf("tbl%0d_op_count", i), op_count, tbl[i].e_cnt);
      if (tbl[i].e_rv) begin
        check($sformatf("tbl%0d_rsp_id", i), rsp_id, tbl[i].e_id);
        check($sformatf("tbl%0d_rsp_y", i), rsp_y, tbl[i].e_y);
      end
      advance();
    end

    // Backpressure: RESP held for 5 cycles with requester 1 waiting.
    drive(0, 1, 4'h1, 4'h2, 4'h3, 0, 4'h0, 4'h0, 4'h0, 0);
    step();                                             // accept requester 0
    drive(0, 0, 4'h0, 4'h0, 4'h0, 1, 4'h7, 4'h8, 4'h4, 0);
    step();                                             // EXEC
    sample();
    held_y  = rsp_y;
    held_id = rsp_id;
    check("bp_rsp_y_first", held_y, ref_alu(4'h1, 4'h2, 4'h3));
    advance();
    for (int i = 1; i < 5; i++) begin
      sample();
      check("bp_rsp_y_stable", rsp_y, held_y);
      check("bp_rsp_id_stable", rsp_id, held_id);
      check("bp_req1_ready_low", req1_ready, 1'b0);
      check("bp_busy_high", busy, 1'b1);
      advance();
    end
    drive(0, 0, 4'h0, 4'h0, 4'h0, 1, 4'h7, 4'h8, 4'h4, 1);
    sample();
    check("bp_handshake_valid", rsp_valid, 1'b1);
    advance();
    sample();
    check("bp_req1_accept_after", req1_ready, 1'b1);
    advance();
    drive(0, 0, 4'h0, 4'h0, 4'h0, 0, 4'h0, 4'h0, 4'h0, 1);
    for (int i = 0; i < 3; i++) step();

    // Select sweep from requester 1, counted from a fresh reset.
    drive(1, 0, 4'h0, 4'h0, 4'h0, 0, 4'h0, 4'h0, 4'h0, 1);
    step();
    for (int s = 0; s < 16; s++) begin
      drive(0, 0, 4'h0, 4'h0, 4'h0, 1, 4'hA, 4'h9, 4'(s), 1);
      sample();
      check("sweep_req1_ready", req1_ready, 1'b1);
      advance();
      drive(0, 0, 4'h0, 4'h0, 4'h0, 0, 4'h0, 4'h0, 4'h0, 1);
      step();
      sample();
      check("sweep_rsp_valid", rsp_valid, 1'b1);
      check($sformatf("sweep_rsp_y_s%0d", s), rsp_y, ref_alu(4'hA, 4'h9, 4'(s)));
      advance();
    end
    sample();
    check("sweep_op_count", op_count, 8'd16);
    advance();

    // Reset during EXEC: operation dropped, pointer back to favouring requester 0.
    drive(0, 1, 4'h2, 4'h2, 4'h0, 0, 4'h0, 4'h0, 4'h0, 1);
    step();
    drive(1, 0, 4'h0, 4'h0, 4'h0, 0, 4'h0, 4'h0, 4'h0, 1);
    sample();
    check("rst_mid_in_exec", busy, 1'b1);
    advance();
    drive(0, 1, 4'h6, 4'h1, 4'h5, 1, 4'h9, 4'h3, 4'h8, 1);
    sample();
    check("rst_mid_no_rsp", rsp_valid, 1'b0);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_alu_a", alu_a, 4'h0);
    check("rst_mid_rsp_y", rsp_y, 8'h00);
    check("rst_mid_op_count", op_count, 8'd0);
    check("rst_mid_tie_req0", req0_ready, 1'b1);
    advance();
    drive(0, 0, 4'h0, 4'h0, 4'h0, 0, 4'h0, 4'h0, 4'h0, 1);
    for (int i = 0; i < 3; i++) step();

    // Counter wrap on the CW=2 instance: 5 completions read back as 1.
    drive(1, 0, 4'h0, 4'h0, 4'h0, 0, 4'h0, 4'h0, 4'h0, 1);
    step();
    for (int k = 0; k < 5; k++) begin
      drive(0, 1, 4'(k), 4'h3, 4'(k), 0, 4'h0, 4'h0, 4'h0, 1);
      step();
      drive(0, 0, 4'h0, 4'h0, 4'h0, 0, 4'h0, 4'h0, 4'h0, 1);
      step();
      step();
    end
    sample();
    check("wrap_cw2_op_count", w_op_count, 2'd1);
    check("wrap_cw8_op_count", op_count, 8'd5);
    advance();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 99) == 0),
            ($urandom_range(0, 9) < 6), 4'($urandom), 4'($urandom), 4'($urandom),
            ($urandom_range(0, 9) < 6), 4'($urandom), 4'($urandom), 4'($urandom),
            ($urandom_range(0, 9) < 7));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
